// File: rtl/data_mem_stage.sv
// data_mem_stage: data-memory access stage that sits directly after the ALU.
// A word-organised on-chip RAM supports byte/half/word stores in one cycle and
// two-cycle loads with sign/zero extension. The first load cycle raises Stall.
// Optional feature macro: DMEM_CLEAR_ON_RESET_EN. When it is defined, a CLEAR
// state zeroes the RAM one word per cycle after reset is released.
//
// Handshake: a request (Mem_Read/Mem_Write) is taken in IDLE when Stall=0 or,
// for a load, on the Stall=1 cycle. The requester must hold its inputs while
// Stall=1. Read_Data is valid when Done=1 and keeps that value afterwards.
module data_mem_stage #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  input  logic [1:0]  Mem_Size,
  input  logic        Mem_Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] Write_Data,
  output logic [31:0] Read_Data,
  output logic        Done,
  output logic        Stall,
  output logic        Misaligned,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef DMEM_CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_CLEAR = 2'd2} state_t;
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1} state_t;
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t state_q, state_d;
  logic [31:0] read_data_q, read_data_d;
  logic        done_q, done_d;

  logic [31:0] mem [0:DEPTH-1];

  logic [DEPTH_LOG2-1:0] idx;
  logic [DEPTH_LOG2-1:0] widx;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic                  we;
  logic                  req_active;
  logic                  mis_raw;
  logic                  unused_addr_bits;

`ifdef DMEM_CLEAR_ON_RESET_EN
  logic [DEPTH_LOG2-1:0] clr_cnt_q, clr_cnt_d;
`endif

  // Address bits above the RAM index are ignored, so accesses wrap.
  assign idx              = Addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^Addr[31:DEPTH_LOG2+2];
  assign req_active       = Mem_Read | Mem_Write;
  // Size 11 behaves as a word access.
  assign mis_raw = ((Mem_Size == 2'b01) && Addr[0]) ||
                   (Mem_Size[1] && (Addr[1:0] != 2'b00));

  // Select the lane(s) addressed by lo/sz from a RAM word, then sign- or zero-extend.
  function automatic logic [31:0] extend_lane(input logic [31:0] w, input logic [1:0] lo,
                                              input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Next state, load capture, store byte enables and the combinational Stall/Misaligned.
  always_comb begin
    state_d     = state_q;
    read_data_d = read_data_q;
    done_d      = 1'b0;
    Stall       = 1'b0;
    Misaligned  = req_active & mis_raw;
    we          = 1'b0;
    be          = 4'h0;
    wdata       = 32'h0;
    widx        = idx;
`ifdef DMEM_CLEAR_ON_RESET_EN
    clr_cnt_d   = clr_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // A store wins over a simultaneous load; misaligned requests do nothing.
        if (Mem_Write && !mis_raw) begin
          we = 1'b1;
          case (Mem_Size)
            2'b00: begin
              be    = 4'b0001 << Addr[1:0];
              wdata = {4{Write_Data[7:0]}};
            end
            2'b01: begin
              be    = Addr[1] ? 4'b1100 : 4'b0011;
              wdata = {2{Write_Data[15:0]}};
            end
            default: begin
              be    = 4'b1111;
              wdata = Write_Data;
            end
          endcase
        end else if (Mem_Read && !Mem_Write && !mis_raw) begin
          Stall       = 1'b1;
          state_d     = ST_LOAD;
          read_data_d = extend_lane(mem[idx], Addr[1:0], Mem_Size, Mem_Unsigned);
          done_d      = 1'b1;
        end
      end
      ST_LOAD: begin
        // Requests still held from the stall cycle are ignored here.
        state_d = ST_IDLE;
      end
`ifdef DMEM_CLEAR_ON_RESET_EN
      ST_CLEAR: begin
        Stall      = 1'b1;
        Misaligned = 1'b0;
        we         = 1'b1;
        be         = 4'b1111;
        wdata      = 32'h0;
        widx       = clr_cnt_q;
        clr_cnt_d  = clr_cnt_q + DEPTH_LOG2'(1);
        if (clr_cnt_q == '1) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      read_data_q <= 32'h0;
      done_q      <= 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
      clr_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      done_q      <= done_d;
`ifdef DMEM_CLEAR_ON_RESET_EN
      clr_cnt_q   <= clr_cnt_d;
`endif
    end
  end

  // RAM byte-lane writes; contents are not touched by reset itself.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign Read_Data = read_data_q;
  assign Done      = done_q;
  assign dbg_state = state_q;

endmodule
